// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg: ALU function codes, HI/LO FSM states and default latencies.
package hilo_unit_pkg;
    localparam logic [3:0] FN_MULT  = 4'b1100;
    localparam logic [3:0] FN_MULTU = 4'b1101;
    localparam logic [3:0] FN_DIV   = 4'b1110;
    localparam logic [3:0] FN_DIVU  = 4'b1111;
    localparam logic [1:0] FN_GRP   = 2'b11;
    localparam int DEF_MULT_LAT = 4;
    localparam int DEF_DIV_LAT  = 32;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/hilo_unit_lat_counter.sv
// lat_counter: loadable down-counter that stops at zero and flags it.
module lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: multi-cycle HI/LO stage; buffers mult/div results, commits after
// the modelled latency, serves MF/MT and stalls the pipe while busy.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op_func,
    input  logic [31:0] alu_lo,
    input  logic [31:0] alu_hi,
    input  logic        alu_ovf,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] mt_data,
    input  logic        mf_hi,
    input  logic        mf_lo,
    output logic [31:0] mf_data,
    output logic        mf_valid,
    output logic        busy,
    output logic        stall,
    output logic        dz_err
);
    localparam int MAX_LAT = MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT) + 1;

    state_t state;
    logic [31:0] hi_reg, lo_reg, pend_hi, pend_lo;
    logic grp, accept, dz, take, zero;
    logic [CW-1:0] lat_val;

    assign grp     = op_valid && op_func[3:2] == FN_GRP;
    assign busy    = state == BUSY;
    assign accept  = !busy && grp;
    assign dz      = accept && alu_ovf && (op_func == FN_DIV || op_func == FN_DIVU);
    assign take    = accept && !dz;
    assign lat_val = op_func[1] ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
    assign stall   = busy && (grp || mt_hi || mt_lo || mf_hi || mf_lo);
    assign mf_valid = !busy && (mf_hi || mf_lo);
    assign mf_data  = mf_hi ? hi_reg : lo_reg;

    lat_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (take),
        .en       (busy),
        .load_val (lat_val),
        .zero     (zero)
    );

    // An MT in the accept cycle lands now; the later commit overwrites it.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            hi_reg  <= '0;
            lo_reg  <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            dz_err  <= 1'b0;
        end else begin
            dz_err <= dz;
            if (take) begin
                pend_hi <= alu_hi;
                pend_lo <= alu_lo;
                state   <= BUSY;
            end
            if (busy && zero) begin
                hi_reg <= pend_hi;
                lo_reg <= pend_lo;
                state  <= IDLE;
            end
            if (!busy && mt_hi) hi_reg <= mt_data;
            if (!busy && mt_lo) lo_reg <= mt_data;
        end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: scenario tasks with a queue of expected MF read values.
module tb_hilo_unit;
    import hilo_unit_pkg::*;

    logic clk = 0, rst = 1, op_valid = 0, alu_ovf = 0;
    logic mt_hi = 0, mt_lo = 0, mf_hi = 0, mf_lo = 0;
    logic [3:0]  op_func = 0;
    logic [31:0] alu_lo = 0, alu_hi = 0, mt_data = 0;
    logic [31:0] mf_data;
    logic mf_valid, busy, stall, dz_err;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    hilo_unit #(.MULT_LAT(4), .DIV_LAT(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_func(op_func),
        .alu_lo(alu_lo), .alu_hi(alu_hi), .alu_ovf(alu_ovf),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
        .mf_hi(mf_hi), .mf_lo(mf_lo), .mf_data(mf_data), .mf_valid(mf_valid),
        .busy(busy), .stall(stall), .dz_err(dz_err)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] f, input logic [31:0] hi, input logic [31:0] lo, input logic ovf);
        op_valid = 1; op_func = f; alu_hi = hi; alu_lo = lo; alu_ovf = ovf;
    endtask

    task automatic idle_inputs();
        op_valid = 0; op_func = 0; alu_ovf = 0; mt_hi = 0; mt_lo = 0; mf_hi = 0; mf_lo = 0;
    endtask

    task automatic drive_mf(input bit hi);
        mf_hi = hi; mf_lo = !hi; #1;
    endtask

    task automatic wait_idle(output int k);
        k = 0;
        while (busy && k < 100) begin k++; step(); end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_cmp++;
        if (busy !== 0 || stall !== 0 || mf_valid !== 0 || mf_data !== 0 || dz_err !== 0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b stall=%b mf_valid=%b mf_data=%h dz_err=%b, want all 0", busy, stall, mf_valid, mf_data, dz_err);
        end
        rst = 0;
        step();
    endtask

    task automatic test_mult_latency();
        int k;
        issue(FN_MULT, 32'h0000_0001, 32'hFFFF_FFFE, 0);
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'hFFFF_FFFE);
        step();
        idle_inputs();
        drive_mf(1);
        n_cmp++;
        if (stall !== 1 || mf_valid !== 0) begin
            n_bad++;
            $display("FAIL mult_mf_stall: stall=%b mf_valid=%b, want 1/0", stall, mf_valid);
        end
        idle_inputs();
        wait_idle(k);
        n_cmp++;
        if (k !== 4) begin n_bad++; $display("FAIL mult_busy_cycles: got %0d want 4", k); end
        drive_mf(1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_valid !== 1 || mf_data !== exp_v) begin
            n_bad++;
            $display("FAIL mult_hi: got %h valid=%b want %h", mf_data, mf_valid, exp_v);
        end
        drive_mf(0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL mult_lo: got %h want %h", mf_data, exp_v); end
        idle_inputs();
    endtask

    task automatic test_div_latency();
        int k;
        issue(FN_DIVU, 32'd3, 32'd7, 0);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd7);
        step();
        issue(FN_DIV, 32'd99, 32'd99, 0);
        #1;
        n_cmp++;
        if (stall !== 1) begin n_bad++; $display("FAIL div_second_stall: got %b want 1", stall); end
        step();
        idle_inputs();
        wait_idle(k);
        n_cmp++;
        if (k + 1 !== 32) begin n_bad++; $display("FAIL div_busy_cycles: got %0d want 32", k + 1); end
        drive_mf(1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL div_hi: got %h want %h", mf_data, exp_v); end
        drive_mf(0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL div_lo: got %h want %h", mf_data, exp_v); end
        idle_inputs();
        #1;
        n_cmp++;
        if (busy !== 0) begin n_bad++; $display("FAIL div_not_reaccepted: busy=%b want 0", busy); end
    endtask

    task automatic test_div_zero();
        mt_hi = 1; mt_data = 32'hAAAA_AAAA;
        step();
        idle_inputs();
        issue(FN_DIV, 32'd5, 32'd6, 1);
        exp_q.push_back(32'hAAAA_AAAA);
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (dz_err !== 1 || busy !== 0) begin
            n_bad++;
            $display("FAIL dz_pulse: dz_err=%b busy=%b want 1/0", dz_err, busy);
        end
        step();
        n_cmp++;
        if (dz_err !== 0) begin n_bad++; $display("FAIL dz_one_cycle: got %b want 0", dz_err); end
        drive_mf(1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL dz_hi_kept: got %h want %h", mf_data, exp_v); end
        idle_inputs();
    endtask

    task automatic test_mt_mf();
        int k;
        mt_hi = 1; mt_lo = 1; mt_data = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
        step();
        idle_inputs();
        drive_mf(1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL mt_both_hi: got %h want %h", mf_data, exp_v); end
        drive_mf(0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL mt_both_lo: got %h want %h", mf_data, exp_v); end
        mf_hi = 1; mf_lo = 1; #1;
        n_cmp++;
        if (mf_data !== 32'h1234_5678 || mf_valid !== 1) begin
            n_bad++;
            $display("FAIL mf_both_hi_wins: got %h valid=%b want 12345678/1", mf_data, mf_valid);
        end
        idle_inputs();
        mt_hi = 1; mt_lo = 1; mt_data = 32'hDEAD_BEEF;
        issue(FN_MULTU, 32'd0, 32'd5, 0);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd0);
        step();
        idle_inputs();
        wait_idle(k);
        drive_mf(0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL mt_op_lo: got %h want %h", mf_data, exp_v); end
        drive_mf(1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL mt_op_hi: got %h want %h", mf_data, exp_v); end
        idle_inputs();
    endtask

    task automatic test_non_mult();
        issue(4'b0000, 32'h5555_5555, 32'h6666_6666, 0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd5);
        #1;
        n_cmp++;
        if (stall !== 0) begin n_bad++; $display("FAIL nonmult_stall: got %b want 0", stall); end
        step();
        idle_inputs();
        n_cmp++;
        if (busy !== 0) begin n_bad++; $display("FAIL nonmult_busy: got %b want 0", busy); end
        drive_mf(1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL nonmult_hi: got %h want %h", mf_data, exp_v); end
        drive_mf(0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL nonmult_lo: got %h want %h", mf_data, exp_v); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int k;
        issue(FN_MULT, 32'd11, 32'd22, 0);
        exp_q.push_back(32'd22);
        exp_q.push_back(32'd33);
        exp_q.push_back(32'd44);
        step();
        idle_inputs();
        wait_idle(k);
        issue(FN_MULT, 32'd33, 32'd44, 0);
        mf_lo = 1; #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (stall !== 0 || mf_valid !== 1 || mf_data !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_first_idle: stall=%b valid=%b data=%h want 0/1/%h", stall, mf_valid, mf_data, exp_v);
        end
        step();
        idle_inputs();
        n_cmp++;
        if (busy !== 1) begin n_bad++; $display("FAIL b2b_accept: busy=%b want 1", busy); end
        wait_idle(k);
        n_cmp++;
        if (k !== 4) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 4", k); end
        drive_mf(1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL b2b_hi: got %h want %h", mf_data, exp_v); end
        drive_mf(0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_data !== exp_v) begin n_bad++; $display("FAIL b2b_lo: got %h want %h", mf_data, exp_v); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        issue(FN_MULT, 32'd7, 32'd9, 0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        step();
        idle_inputs();
        step();
        rst = 1; #1;
        n_cmp++;
        if (busy !== 0 || stall !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_busy: busy=%b stall=%b want 0/0", busy, stall);
        end
        step();
        rst = 0;
        drive_mf(0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mf_valid !== 1 || mf_data !== exp_v) begin
            n_bad++;
            $display("FAIL rst_mid_lo: got %h valid=%b want %h/1", mf_data, mf_valid, exp_v);
        end
        idle_inputs();
        repeat (6) step();
        drive_mf(1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (busy !== 0 || mf_data !== exp_v) begin
            n_bad++;
            $display("FAIL rst_mid_discard: busy=%b hi=%h want 0/%h", busy, mf_data, exp_v);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_mult_latency();
        test_div_latency();
        test_div_zero();
        test_mt_mf();
        test_non_mult();
        test_back_to_back();
        test_reset_mid_op();
        n_cmp++;
        if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multi-cycle HI/LO register stage directly downstream of the ALU. It captures the 64-bit multiply results and the quotient/remainder results (`alufunc` 1100–1111) into pending buffers. It models the multiply/divide latency with a countdown and commits to the architectural HI/LO registers when the countdown expires. It serves MFHI/MFLO/MTHI/MTLO and generates the pipeline stall while an operation is in flight.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- MULT_LAT, default 4: cycles from accepting MULT/MULTU to HI/LO commit (≥1).
- DIV_LAT, default 32: cycles from accepting DIV/DIVU to HI/LO commit (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- op_valid  in  1  issue request for the op on op_func.
- op_func  in  4  ALU function code; only 11xx is acted on.
- alu_lo  in  32  ALU `result` (product low word or quotient).
- alu_hi  in  32  ALU `HI` (product high word or remainder).
- alu_ovf  in  1  ALU `overflow`; for 111x it is the divide-by-zero flag.
- mt_hi  in  1  MTHI write strobe.
- mt_lo  in  1  MTLO write strobe.
- mt_data  in  32  MTHI/MTLO data.
- mf_hi  in  1  MFHI read request.
- mf_lo  in  1  MFLO read request.
- mf_data  out  32  read data (combinational from HI/LO).
- mf_valid  out  1  mf_data is valid this cycle.
- busy  out  1  operation in flight.
- stall  out  1  the current request cannot be served this cycle.
- dz_err  out  1  one-cycle pulse: a divide by zero was rejected.

## Operation
- State machine has two states: IDLE and BUSY.
- Storage:
  - HI and LO architectural registers.
  - pend_hi and pend_lo buffers.
  - cnt down-counter, width $clog2(max(MULT_LAT,DIV_LAT))+1.
- Accept condition: IDLE & op_valid & op_func[3:2]==2'b11.
  - Normal accept: pend_hi←alu_hi, pend_lo←alu_lo, cnt←(op_func[1] ? DIV_LAT : MULT_LAT)−1, go to BUSY.
  - Divide by zero (op_func[3:1]==3'b111 & alu_ovf): nothing is captured, the FSM stays IDLE, HI/LO are unchanged, and dz_err pulses at the next edge.
- BUSY behaviour:
  - If cnt==0: HI←pend_hi, LO←pend_lo, go to IDLE.
  - Otherwise cnt←cnt−1.
- busy = (state==BUSY).
- stall = busy & (op_valid&op_func[3:2]==2'b11 | mt_hi | mt_lo | mf_hi | mf_lo).
  - A stalled request must be held by the pipeline. This block does not queue it.
- op_valid with op_func[3:2]!=2'b11 is ignored in both states.
- MT requests:
  - In IDLE, mt_hi writes HI and mt_lo writes LO at the edge. Both may assert together and both write.
  - mt in the same IDLE cycle as an op accept: the MT write happens, then the op commit overwrites both registers.
- MF requests:
  - mf_valid = ~busy & (mf_hi|mf_lo).
  - mf_data = mf_hi ? HI : LO. If both are asserted, mf_hi wins.
  - When mf_valid=0, mf_data still shows the mux value. It is don't-care to consumers.
- Reset (any time, including mid-operation):
  - HI=LO=pend=0, cnt=0, state=IDLE, dz_err=0.
  - Any in-flight result is discarded.
  - After reset, busy=0, mf_valid=0, stall=0, and mf_data=0.

## Timing
- Op accepted at edge E0: busy is high from after E0 through the cycle before E0+LAT. HI/LO take the new values at edge E0+LAT. A MF in the cycle after E0+LAT returns the new value.
- Back-to-back ops: a new op is accepted in the first IDLE cycle. Its earliest accept edge is E0+LAT+1.
- stall, mf_valid and mf_data are combinational; there is no latency from request to response.
- dz_err is registered: it is high for exactly the one cycle after the rejecting edge.

## Structure
- Shared package holds:
  - the ALU function-code constants (FN_MULT=4'b1100, FN_MULTU, FN_DIV, FN_DIVU, and group mask 2'b11),
  - the FSM state enum {IDLE, BUSY},
  - default latency constants.
  The ALU and the decoder use the same package.
- One natural sub-module: `lat_counter`, a loadable down-counter with a zero flag, parameterised by width.

## Test plan
- Reset mid-op: MULT accepted, assert rst after 2 cycles → busy=0, HI=LO=0 immediately; MFLO next cycle → mf_data=0, mf_valid=1.
- MULT latency: MULT with alu_hi=32'h0000_0001, alu_lo=32'hFFFF_FFFE at E0, MULT_LAT=4 → busy for 4 cycles; MFHI at E0+1 → stall=1, mf_valid=0; MFHI at E0+5 → mf_data=32'h1.
- DIV latency: DIVU with alu_lo=7, alu_hi=3 at E0, DIV_LAT=32 → LO=7, HI=3 at edge E0+32; a second DIV at E0+1 → stall=1, not accepted.
- Divide by zero: DIV with alu_ovf=1, HI=32'hAAAA_AAAA beforehand → dz_err=1 for one cycle, busy stays 0, HI=32'hAAAA_AAAA.
- MT/MF collision: IDLE, mt_hi=mt_lo=1, mt_data=32'h1234_5678 → both read back 32'h1234_5678. Same cycle as MULT accept (lo=5, hi=0) → after commit, LO=5, HI=0.
- Non-mult op: op_valid with op_func=4'b0000 → no busy, no stall, HI/LO unchanged.
